// File: rtl/reg_file_pkg.sv
// Shared constants and default-width types for the register file / scoreboard slice.
package reg_file_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned PW_DEFAULT = 3;

  typedef logic [PW_DEFAULT-1:0] reg_addr_t;
  typedef logic [DW_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending scoreboard: load-issue set, load-return clear, sticky double-issue error.
// Optional REG_FILE_SB_BYPASS_EN: a same-cycle load return hides the stall on a matching read port.
module reg_scoreboard #(
  parameter int unsigned pw      = 3,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pend_set,
  input  logic [pw-1:0] i_pend_addr,
  input  logic          i_ld_wr_en,
  input  logic [pw-1:0] i_ld_addr,
  input  logic [pw-1:0] i_rd_addrA,
  input  logic [pw-1:0] i_rd_addrB,
  output logic          o_stallA,
  output logic          o_stallB,
  output logic          o_pend_err
);

  localparam int unsigned DEPTH = 2 ** pw;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             r_err;
  logic             w_set_ok;
  logic             w_err_hit;

  assign w_set_ok  = i_pend_set && !(R0_ZERO && (i_pend_addr == '0));
  assign w_err_hit = w_set_ok && r_pend[i_pend_addr]
                   && !(i_ld_wr_en && (i_ld_addr == i_pend_addr));

  // Set is applied after clear so a back-to-back load to the same register stays pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_ld_wr_en) w_pend_nxt[i_ld_addr] = 1'b0;
    if (w_set_ok)   w_pend_nxt[i_pend_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  always_comb begin
    o_stallA = r_pend[i_rd_addrA];
    o_stallB = r_pend[i_rd_addrB];
`ifdef REG_FILE_SB_BYPASS_EN
    if (i_ld_wr_en && (i_ld_addr == i_rd_addrA)) o_stallA = 1'b0;
    if (i_ld_wr_en && (i_ld_addr == i_rd_addrB)) o_stallB = 1'b0;
`endif
  end

  assign o_pend_err = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with ALU and load-return write ports plus pending scoreboard.
// Optional REG_FILE_SB_BYPASS_EN: same-cycle write-to-read forwarding on all read outputs.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned dw      = DW_DEFAULT,
  parameter int unsigned pw      = PW_DEFAULT,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [pw-1:0] wr_addr,
  input  logic [dw-1:0] dat_in,
  input  logic          ld_wr_en,
  input  logic [pw-1:0] ld_addr,
  input  logic [dw-1:0] ld_dat,
  input  logic          pend_set,
  input  logic [pw-1:0] pend_addr,
  input  logic [pw-1:0] rd_addrA,
  input  logic [pw-1:0] rd_addrB,
  output logic [dw-1:0] datA_out,
  output logic [dw-1:0] datB_out,
  output logic [dw-1:0] dat0_out,
  output logic          stallA,
  output logic          stallB,
  output logic          pend_err
);

  localparam int unsigned DEPTH = 2 ** pw;

  logic [dw-1:0] r_core [DEPTH];
  logic          w_wr_ok;
  logic          w_ld_ok;

  assign w_wr_ok = wr_en    && !(R0_ZERO && (wr_addr == '0));
  assign w_ld_ok = ld_wr_en && !(R0_ZERO && (ld_addr == '0));

  // The ALU port is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core <= '{default: '0};
    end else begin
      if (w_ld_ok) r_core[ld_addr] <= ld_dat;
      if (w_wr_ok) r_core[wr_addr] <= dat_in;
    end
  end

  function automatic logic [dw-1:0] f_read(input logic [pw-1:0] addr);
    f_read = r_core[addr];
`ifdef REG_FILE_SB_BYPASS_EN
    if (w_ld_ok && (ld_addr == addr)) f_read = ld_dat;
    if (w_wr_ok && (wr_addr == addr)) f_read = dat_in;
`endif
    if (R0_ZERO && (addr == '0)) f_read = '0;
  endfunction

  always_comb begin
    datA_out = f_read(rd_addrA);
    datB_out = f_read(rd_addrB);
    dat0_out = f_read('0);
  end

  reg_scoreboard #(
    .pw      (pw),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_pend_set  (pend_set),
    .i_pend_addr (pend_addr),
    .i_ld_wr_en  (ld_wr_en),
    .i_ld_addr   (ld_addr),
    .i_rd_addrA  (rd_addrA),
    .i_rd_addrB  (rd_addrB),
    .o_stallA    (stallA),
    .o_stallB    (stallB),
    .o_pend_err  (pend_err)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default instance plus an R0_ZERO=1 instance on shared stimulus.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, ld_wr_en, pend_set;
  logic [2:0] wr_addr, ld_addr, pend_addr, rd_addrA, rd_addrB;
  logic [7:0] dat_in, ld_dat;
  logic [7:0] datA_out, datB_out, dat0_out;
  logic       stallA, stallB, pend_err;
  logic [7:0] z_datA, z_datB, z_dat0;
  logic       z_stallA, z_stallB, z_err;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
    .pend_set(pend_set), .pend_addr(pend_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA_out), .datB_out(datB_out), .dat0_out(dat0_out),
    .stallA(stallA), .stallB(stallB), .pend_err(pend_err)
  );

  reg_file_sb #(.R0_ZERO(1'b1)) u_dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
    .pend_set(pend_set), .pend_addr(pend_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(z_datA), .datB_out(z_datB), .dat0_out(z_dat0),
    .stallA(z_stallA), .stallB(z_stallB), .pend_err(z_err)
  );

  typedef struct {
    string      nm;
    logic [7:0] a, b, d0;
    logic       sa, sb, er, zsa;
  } exp_t;

  exp_t q[$];
  logic obs_v = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: consumes one expectation per observed cycle, mid-cycle.
  always @(negedge clk) begin
    if (obs_v) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, ".datA"},   datA_out, e.a);
        chk({e.nm, ".datB"},   datB_out, e.b);
        chk({e.nm, ".dat0"},   dat0_out, e.d0);
        chk({e.nm, ".stallA"}, {7'd0, stallA}, {7'd0, e.sa});
        chk({e.nm, ".stallB"}, {7'd0, stallB}, {7'd0, e.sb});
        chk({e.nm, ".err"},    {7'd0, pend_err}, {7'd0, e.er});
        chk({e.nm, ".z_dat0"}, z_dat0, 8'h00);
        chk({e.nm, ".z_stallA"}, {7'd0, z_stallA}, {7'd0, e.zsa});
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic le, input logic [2:0] la, input logic [7:0] ld,
                       input logic ps, input logic [2:0] pa,
                       input logic [2:0] ra, input logic [2:0] rb);
    wr_en = we; wr_addr = wa; dat_in = wd;
    ld_wr_en = le; ld_addr = la; ld_dat = ld;
    pend_set = ps; pend_addr = pa;
    rd_addrA = ra; rd_addrB = rb;
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, ra, rb);
  endtask

  task automatic exp_out(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d0, input logic sa, input logic sb,
                         input logic er, input logic zsa);
    exp_t e;
    e.nm = nm; e.a = a; e.b = b; e.d0 = d0;
    e.sa = sa; e.sb = sb; e.er = er; e.zsa = zsa;
    q.push_back(e);
    obs_v = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    obs_v = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(3'd0, 3'd0);
    tick; tick;
    reset = 1'b0;
    exp_out("rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0); tick;
    idle(3'd3, 3'd0);
    exp_out("wr_r3", 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    reset = 1'b1;
    drive(1'b1, 3'd3, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0); tick;
    reset = 1'b0;
    idle(3'd3, 3'd0);
    exp_out("rst_clr", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, 3'd0, 3'd2, 3'd5);
    exp_out("dual_pre", BYP ? 8'h11 : 8'h00, BYP ? 8'h22 : 8'h00, 8'h00,
            1'b0, 1'b0, 1'b0, 1'b0); tick;
    idle(3'd2, 3'd5);
    exp_out("dual", 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b1, 3'd4, 8'h33, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 3'd4, 3'd4);
    exp_out("same_pre", BYP ? 8'h33 : 8'h00, BYP ? 8'h33 : 8'h00, 8'h00,
            1'b0, 1'b0, 1'b0, 1'b0); tick;
    idle(3'd4, 3'd4);
    exp_out("same", 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 3'd6); tick;
    repeat (3) begin
      idle(3'd0, 3'd6);
      exp_out("stall", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick;
    end
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h7E, 1'b0, 3'd0, 3'd0, 3'd6);
    exp_out("ld_pre", 8'h00, BYP ? 8'h7E : 8'h00, 8'h00, 1'b0, !BYP, 1'b0, 1'b0); tick;
    idle(3'd0, 3'd6);
    exp_out("ld_done", 8'h00, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd0, 3'd0); tick;
    drive(1'b1, 3'd7, 8'h5C, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd7, 3'd0);
    exp_out("byp_wr", BYP ? 8'h5C : 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    idle(3'd7, 3'd0);
    exp_out("wr_pend", 8'h5C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'hAB, 1'b0, 3'd0, 3'd7, 3'd0);
    exp_out("byp_ld", BYP ? 8'hAB : 8'h5C, 8'h00, 8'h00, !BYP, 1'b0, 1'b0, !BYP); tick;
    idle(3'd7, 3'd0);
    exp_out("ld_r7", 8'hAB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd0); tick;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h09, 1'b1, 3'd1, 3'd1, 3'd0);
    exp_out("coll_pre", BYP ? 8'h09 : 8'h00, 8'h00, 8'h00, !BYP, 1'b0, 1'b0, !BYP); tick;
    idle(3'd1, 3'd0);
    exp_out("coll", 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd0);
    exp_out("dbl_pre", 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    idle(3'd1, 3'd0);
    exp_out("dbl_err", 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); tick;
    idle(3'd1, 3'd0);
    exp_out("err_sticky", 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); tick;

    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd0); tick;
    idle(3'd0, 3'd0);
    exp_out("r0", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0); tick;

    reset = 1'b1;
    idle(3'd0, 3'd0); tick;
    reset = 1'b0;
    exp_out("rst_err", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick;

    tick;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the 8x8 core register file: configurable data width and depth, a synchronous reset that clears all registers, and a second write port for load data that returns late.
- Adds a per-register pending scoreboard. Decode marks a destination busy when a multi-cycle load issues. Read ports raise a stall while any source register is still busy.
- Sits between decode (read/issue side) and the ALU/data-memory writeback paths of the CPU core.

Parameters:
- dw, 8, data width in bits.
- pw, 3, address pointer width; depth = 2**pw.
- R0_ZERO, 0, when 1, register 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  ALU write port enable.
- wr_addr  in  pw  ALU write address.
- dat_in  in  dw  ALU write data.
- ld_wr_en  in  1  load-return write enable; also clears pending.
- ld_addr  in  pw  load-return address.
- ld_dat  in  dw  load-return data.
- pend_set  in  1  mark pend_addr busy (load issued).
- pend_addr  in  pw  register to mark busy.
- rd_addrA  in  pw  read pointer A.
- rd_addrB  in  pw  read pointer B.
- datA_out  out  dw  read data A.
- datB_out  out  dw  read data B.
- dat0_out  out  dw  contents of register 0.
- stallA  out  1  pending bit of rd_addrA.
- stallB  out  1  pending bit of rd_addrB.
- pend_err  out  1  sticky: pend_set hit an already-pending register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
  - On a reset edge: all registers become 0, all pending bits become 0, pend_err becomes 0.
  - Reset overrides every same-cycle write, pend_set and ld_wr_en. An in-flight load is forgotten; its later ld_wr_en still writes data.
- Reads are combinational: datA_out = core[rd_addrA], datB_out = core[rd_addrB], dat0_out = core[0].
- Writes occur on the posedge.
  - Both ports enabled at different addresses: both writes commit.
  - Same address: the wr_en port wins and ld_dat is discarded. The pending bit is still cleared.
- Pending bits:
  - Set on a posedge with pend_set.
  - Cleared on a posedge with ld_wr_en at that address.
  - Clear and set in the same cycle at the same address: set wins (back-to-back load to the same destination).
  - pend_set on a register that is already pending and is not being cleared that cycle: pend_err goes to 1 and stays there until reset. The pending bit stays 1.
  - wr_en to a pending register writes data but does not clear the pending bit.
- stallA = pend[rd_addrA], stallB = pend[rd_addrB]; combinational, zero latency.
- R0_ZERO=1:
  - core[0] is held at 0; dat0_out = 0.
  - Writes to address 0 on either port are dropped.
  - pend_set on address 0 is ignored; the stall outputs never assert for address 0.
- Latency: a write is visible on the read ports the cycle after the write edge (without the optional feature).

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- With it defined: write-to-read forwarding.
  - If rd_addrX matches an active write this cycle, datX_out shows the incoming data in the same cycle. The wr_en port takes priority over the ld port.
  - If ld_wr_en matches rd_addrX, stallX is forced to 0 that cycle.
  - dat0_out is forwarded the same way.
- Without it: reads show only the stored state; stall clears the cycle after ld_wr_en.

Decomposition:
- Package reg_file_pkg:
  - constants DW_DEFAULT=8, PW_DEFAULT=3.
  - typedef reg_addr_t (logic[pw-1:0]) and reg_data_t (logic[dw-1:0]) for the defaults.
- One natural sub-module, reg_scoreboard: owns the pend vector, set/clear priority, pend_err and the stall lookups. The data array stays in the top module.

Test Plan:
- Reset: write 8'hA5 to r3, assert reset for 1 cycle, read rd_addrA=3 -> datA_out=0, stallA=0, pend_err=0.
- Dual write:
  - wr_en r2=8'h11 and ld_wr_en r5=8'h22 in the same cycle -> next cycle r2=11, r5=22.
  - Both ports to r4 (8'h33 vs 8'h44) -> r4=8'h33.
- Scoreboard:
  - pend_set r6, then read rd_addrB=6 -> stallB=1 for 3 idle cycles.
  - ld_wr_en r6=8'h7E -> next cycle stallB=0, datB_out=8'h7E.
- Set/clear collision: r1 pending; same cycle ld_wr_en r1=8'h09 and pend_set r1 -> r1=8'h09, stall on r1 remains 1, pend_err=0. A second pend_set r1 with no clear -> pend_err=1 and stays 1.
- R0_ZERO=1: wr_en r0=8'hFF, pend_set r0 -> dat0_out=0, stall on r0 stays 0.
- BYPASS_EN: wr_en r7=8'h5C with rd_addrA=7 in the same cycle -> datA_out=8'h5C combinationally. ld_wr_en on a pending r7 -> stallA=0 in that cycle.
